// File: rtl/chime_alarm_ctrl_if.sv
`default_nettype none
// ============================================================================
// chime_alarm_ctrl_if : BCD time, control strobes and buzzer/status outputs
// Rev 1.0
// ============================================================================
interface chime_alarm_ctrl_if;
  logic [3:0] h_cntH, h_cntL, m_cntH, m_cntL, s_cntH, s_cntL;
  logic       sec_tick;
  logic       chime_en;
  logic       alarm_en;
  logic       set_alarm;
  logic [7:0] set_h, set_m;
  logic       snooze_btn;
  logic       stop_btn;
  logic       alarm;
  logic       ringing;
  logic       snoozing;
  logic       set_err;

  modport master (
    output h_cntH, h_cntL, m_cntH, m_cntL, s_cntH, s_cntL, sec_tick,
           chime_en, alarm_en, set_alarm, set_h, set_m, snooze_btn, stop_btn,
    input  alarm, ringing, snoozing, set_err
  );

  modport slave (
    input  h_cntH, h_cntL, m_cntH, m_cntL, s_cntH, s_cntL, sec_tick,
           chime_en, alarm_en, set_alarm, set_h, set_m, snooze_btn, stop_btn,
    output alarm, ringing, snoozing, set_err
  );
endinterface
`default_nettype wire

// File: rtl/chime_alarm_ctrl.sv
`default_nettype none
// ============================================================================
// chime_alarm_ctrl : hourly chime plus HH:MM wake alarm with snooze/stop
// Rev 1.0
// ============================================================================
module chime_alarm_ctrl #(
  parameter int TONE_LO_HALF = 32,
  parameter int TONE_HI_HALF = 16,
  parameter int PRE_BEEPS    = 8,
  parameter int RING_SECS    = 60,
  parameter int SNOOZE_MIN   = 5,
  parameter int MAX_SNOOZE   = 3
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  chime_alarm_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } state_t;

  localparam int          LO_W       = $clog2(TONE_LO_HALF + 1);
  localparam int          HI_W       = $clog2(TONE_HI_HALF + 1);
  localparam logic [7:0]  RING_LAST  = 8'(RING_SECS - 1);
  localparam logic [11:0] SN_LAST    = 12'(SNOOZE_MIN * 60 - 1);
  localparam logic [2:0]  SNOOZE_LIM = 3'(MAX_SNOOZE);
  localparam logic [7:0]  PRE_FIRST  = 8'(59 - PRE_BEEPS);

  state_t            state_q, state_d;
  logic [LO_W-1:0]   lo_cnt_q;
  logic [HI_W-1:0]   hi_cnt_q;
  logic              tone_lo_q, tone_hi_q;
  logic [7:0]        ring_cnt_q, ring_cnt_d;
  logic [11:0]       sn_cnt_q, sn_cnt_d;
  logic [2:0]        snooze_cnt_q, snooze_cnt_d;
  logic [7:0]        tgt_h_q, tgt_m_q;
  logic              alarm_q, ringing_q, snoozing_q, set_err_q;
  logic              alarm_d, chime_d;

  logic [7:0] sec_bin, set_h_bin, set_m_bin;
  logic       set_ok, set_take, at_target, minute59;

  // Seconds and set values are compared in binary, not BCD.
  assign sec_bin   = 8'(bus.s_cntH) * 8'd10 + 8'(bus.s_cntL);
  assign set_h_bin = 8'(bus.set_h[7:4]) * 8'd10 + 8'(bus.set_h[3:0]);
  assign set_m_bin = 8'(bus.set_m[7:4]) * 8'd10 + 8'(bus.set_m[3:0]);

  assign set_ok = (bus.set_h[7:4] <= 4'd9) && (bus.set_h[3:0] <= 4'd9) &&
                  (bus.set_m[7:4] <= 4'd9) && (bus.set_m[3:0] <= 4'd9) &&
                  (set_h_bin <= 8'd23) && (set_m_bin <= 8'd59);
  assign set_take = bus.set_alarm && set_ok;

  assign at_target = ({bus.h_cntH, bus.h_cntL} == tgt_h_q) &&
                     ({bus.m_cntH, bus.m_cntL} == tgt_m_q) && (sec_bin == 8'd0);
  assign minute59  = ({bus.m_cntH, bus.m_cntL} == 8'h59);

  always_comb begin
    state_d      = state_q;
    ring_cnt_d   = ring_cnt_q;
    sn_cnt_d     = sn_cnt_q;
    snooze_cnt_d = snooze_cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.sec_tick && bus.alarm_en && at_target && !set_take) begin
          state_d    = RING;
          ring_cnt_d = 8'd0;
        end
      end
      RING: begin
        if (bus.sec_tick && (ring_cnt_q == RING_LAST)) begin
          state_d = IDLE;
        end else if (bus.snooze_btn && (snooze_cnt_q < SNOOZE_LIM)) begin
          state_d      = SNOOZE;
          snooze_cnt_d = snooze_cnt_q + 3'd1;
          sn_cnt_d     = 12'd0;
        end else if (bus.sec_tick) begin
          ring_cnt_d = ring_cnt_q + 8'd1;
        end
      end
      SNOOZE: begin
        if (bus.sec_tick) begin
          if (sn_cnt_q == SN_LAST) begin
            state_d    = RING;
            ring_cnt_d = 8'd0;
          end else begin
            sn_cnt_d = sn_cnt_q + 12'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Stop, alarm disable and a fresh target all abort an active alarm event.
    if ((state_q != IDLE) && (bus.stop_btn || !bus.alarm_en || set_take)) begin
      state_d = IDLE;
    end
    if (state_d == IDLE) begin
      snooze_cnt_d = 3'd0;
    end
  end

  always_comb begin
    chime_d = 1'b0;
    if (bus.chime_en && minute59) begin
      if (sec_bin == 8'd59) begin
        chime_d = tone_hi_q;
      end else if ((sec_bin >= PRE_FIRST) && (sec_bin <= 8'd58)) begin
        chime_d = tone_lo_q;
      end
    end
    alarm_d = (state_d == RING) ? (tone_hi_q & ~bus.s_cntL[0]) : chime_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      lo_cnt_q     <= '0;
      hi_cnt_q     <= '0;
      tone_lo_q    <= 1'b0;
      tone_hi_q    <= 1'b0;
      ring_cnt_q   <= 8'd0;
      sn_cnt_q     <= 12'd0;
      snooze_cnt_q <= 3'd0;
      tgt_h_q      <= 8'h07;
      tgt_m_q      <= 8'h00;
      alarm_q      <= 1'b0;
      ringing_q    <= 1'b0;
      snoozing_q   <= 1'b0;
      set_err_q    <= 1'b0;
    end else begin
      if (lo_cnt_q == LO_W'(TONE_LO_HALF - 1)) begin
        lo_cnt_q  <= '0;
        tone_lo_q <= ~tone_lo_q;
      end else begin
        lo_cnt_q <= lo_cnt_q + 1'b1;
      end
      if (hi_cnt_q == HI_W'(TONE_HI_HALF - 1)) begin
        hi_cnt_q  <= '0;
        tone_hi_q <= ~tone_hi_q;
      end else begin
        hi_cnt_q <= hi_cnt_q + 1'b1;
      end
      state_q      <= state_d;
      ring_cnt_q   <= ring_cnt_d;
      sn_cnt_q     <= sn_cnt_d;
      snooze_cnt_q <= snooze_cnt_d;
      if (set_take) begin
        tgt_h_q <= bus.set_h;
        tgt_m_q <= bus.set_m;
      end
      set_err_q  <= bus.set_alarm && !set_ok;
      alarm_q    <= alarm_d;
      ringing_q  <= (state_d == RING);
      snoozing_q <= (state_d == SNOOZE);
    end
  end

  assign bus.alarm    = alarm_q;
  assign bus.ringing  = ringing_q;
  assign bus.snoozing = snoozing_q;
  assign bus.set_err  = set_err_q;

endmodule
`default_nettype wire

// File: tb/tb_chime_alarm_ctrl.sv
`default_nettype none
// ============================================================================
// tb_chime_alarm_ctrl : vector tables, directed alarm sequences, random run
// Rev 1.0
// ============================================================================
module tb_chime_alarm_ctrl;
  localparam int TLO = 32, THI = 16, PRE = 8, RSECS = 60, SMIN = 5, MAXS = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  chime_alarm_ctrl_if bus ();

  chime_alarm_ctrl #(
    .TONE_LO_HALF(TLO), .TONE_HI_HALF(THI), .PRE_BEEPS(PRE),
    .RING_SECS(RSECS), .SNOOZE_MIN(SMIN), .MAX_SNOOZE(MAXS)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int edges = 0;
  int hh = 0, mm = 0, ss = 0;

  // Reference: an alarm event is either off, ringing with N seconds left, or
  // snoozing with N seconds left; tones are pure functions of elapsed edges.
  bit         m_ring = 0, m_snz = 0;
  int         ring_left = 0, snz_left = 0, used = 0;
  logic [7:0] tgt_h = 8'h07, tgt_m = 8'h00;
  logic       e_alarm = 0, e_err = 0;

  typedef struct { int mn; int sec; int kind; } chime_vec_t;  // kind 0 off,1 low,2 high
  typedef struct { logic [7:0] h; logic [7:0] m; logic err; } set_vec_t;

  function automatic logic tone(int half);
    return logic'(((edges - 1) / half) % 2);
  endfunction

  task automatic chk(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_time(int h, int m, int s);
    hh = h; mm = m; ss = s;
    bus.h_cntH = 4'(h / 10); bus.h_cntL = 4'(h % 10);
    bus.m_cntH = 4'(m / 10); bus.m_cntL = 4'(m % 10);
    bus.s_cntH = 4'(s / 10); bus.s_cntL = 4'(s % 10);
  endtask

  task automatic advance();
    int s, m, h;
    s = ss + 1; m = mm; h = hh;
    if (s == 60) begin s = 0; m++; end
    if (m == 60) begin m = 0; h = (h + 1) % 24; end
    set_time(h, m, s);
  endtask

  task automatic model();
    int sec, sh, smn;
    bit valid;
    logic [7:0] cur_h, cur_m;
    sec   = int'(bus.s_cntH) * 10 + int'(bus.s_cntL);
    cur_h = {bus.h_cntH, bus.h_cntL};
    cur_m = {bus.m_cntH, bus.m_cntL};
    sh    = int'(bus.set_h[7:4]) * 10 + int'(bus.set_h[3:0]);
    smn   = int'(bus.set_m[7:4]) * 10 + int'(bus.set_m[3:0]);
    valid = bus.set_h[7:4] <= 9 && bus.set_h[3:0] <= 9 && bus.set_m[7:4] <= 9 &&
            bus.set_m[3:0] <= 9 && sh <= 23 && smn <= 59;
    e_err = bus.set_alarm && !valid;
    if (bus.set_alarm && valid) begin
      tgt_h = bus.set_h; tgt_m = bus.set_m;
      m_ring = 0; m_snz = 0;
    end else if (!m_ring && !m_snz) begin
      if (bus.sec_tick && bus.alarm_en && cur_h == tgt_h && cur_m == tgt_m && sec == 0) begin
        m_ring = 1; ring_left = RSECS;
      end
    end else if (bus.stop_btn || !bus.alarm_en) begin
      m_ring = 0; m_snz = 0;
    end else if (m_ring) begin
      if (bus.sec_tick && ring_left == 1) m_ring = 0;
      else if (bus.snooze_btn && used < MAXS) begin
        m_ring = 0; m_snz = 1; used++; snz_left = SMIN * 60;
      end else if (bus.sec_tick) ring_left--;
    end else if (bus.sec_tick) begin
      if (snz_left == 1) begin m_snz = 0; m_ring = 1; ring_left = RSECS; end
      else snz_left--;
    end
    if (!m_ring && !m_snz) used = 0;
    if (m_ring) e_alarm = tone(THI) & ~bus.s_cntL[0];
    else if (bus.chime_en && cur_m == 8'h59 && sec == 59) e_alarm = tone(THI);
    else if (bus.chime_en && cur_m == 8'h59 && sec >= 59 - PRE && sec <= 58) e_alarm = tone(TLO);
    else e_alarm = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    edges++;
    model();
    #1;
    chk("alarm", bus.alarm, e_alarm);
    chk("ringing", bus.ringing, m_ring);
    chk("snoozing", bus.snoozing, m_snz);
    chk("set_err", bus.set_err, e_err);
    bus.sec_tick = 0; bus.set_alarm = 0; bus.snooze_btn = 0; bus.stop_btn = 0;
  endtask

  task automatic secs(int n);
    for (int i = 0; i < n; i++) begin
      advance();
      bus.sec_tick = 1;
      step();
      step();
    end
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_alarm", bus.alarm, 1'b0);
    chk("rst_ringing", bus.ringing, 1'b0);
    chk("rst_snoozing", bus.snoozing, 1'b0);
    chk("rst_set_err", bus.set_err, 1'b0);
    m_ring = 0; m_snz = 0; used = 0; tgt_h = 8'h07; tgt_m = 8'h00; edges = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    chime_vec_t cv[12];
    set_vec_t   sv[7];
    logic       exp_tone;

    cv = '{'{59, 50, 0}, '{59, 51, 1}, '{59, 52, 1}, '{59, 53, 1}, '{59, 54, 1},
           '{59, 55, 1}, '{59, 56, 1}, '{59, 57, 1}, '{59, 58, 1}, '{59, 59, 2},
           '{0, 0, 0}, '{58, 55, 0}};
    sv = '{'{8'h24, 8'h00, 1'b1}, '{8'h05, 8'h5A, 1'b1}, '{8'h1A, 8'h00, 1'b1},
           '{8'h00, 8'h60, 1'b1}, '{8'h30, 8'h00, 1'b1}, '{8'h23, 8'h59, 1'b0},
           '{8'h06, 8'h30, 1'b0}};

    bus.sec_tick = 0; bus.set_alarm = 0; bus.snooze_btn = 0; bus.stop_btn = 0;
    bus.chime_en = 0; bus.alarm_en = 0; bus.set_h = 8'h00; bus.set_m = 8'h00;
    set_time(12, 0, 0);
    do_reset();

    // Chime sweep across the last seconds of the hour
    bus.chime_en = 1;
    for (int i = 0; i < 12; i++) begin
      set_time(6, cv[i].mn, cv[i].sec);
      bus.sec_tick = 1;
      for (int c = 0; c < 70; c++) begin
        step();
        exp_tone = (cv[i].kind == 1) ? tone(TLO) : (cv[i].kind == 2) ? tone(THI) : 1'b0;
        chk($sformatf("chime_tbl_s%0d", cv[i].sec), bus.alarm, exp_tone);
      end
    end
    bus.chime_en = 0;

    // Rejected targets keep 07:00
    bus.alarm_en = 1;
    for (int i = 0; i < 5; i++) begin
      bus.set_h = sv[i].h; bus.set_m = sv[i].m; bus.set_alarm = 1;
      step();
      chk("set_tbl_err", bus.set_err, sv[i].err);
      step();
      chk("set_err_pulse", bus.set_err, 1'b0);
    end
    set_time(6, 59, 59);
    secs(1);
    chk("target_kept_0700", bus.ringing, 1'b1);
    bus.stop_btn = 1; step();
    for (int i = 5; i < 7; i++) begin
      bus.set_h = sv[i].h; bus.set_m = sv[i].m; bus.set_alarm = 1;
      step();
      chk("set_tbl_ok", bus.set_err, sv[i].err);
    end

    // Ring at 06:30, auto-stop after RING_SECS ticks
    set_time(6, 29, 59);
    secs(1);
    chk("ring_start", bus.ringing, 1'b1);
    secs(RSECS - 1);
    chk("ring_hold", bus.ringing, 1'b1);
    secs(1);
    chk("ring_autostop", bus.ringing, 1'b0);

    // Snooze three times, fourth ignored
    set_time(6, 29, 59);
    secs(1);
    for (int k = 0; k < MAXS; k++) begin
      secs(2);
      bus.snooze_btn = 1; step();
      chk("snooze_enter", bus.snoozing, 1'b1);
      secs(SMIN * 60 - 1);
      chk("snooze_hold", bus.snoozing, 1'b1);
      secs(1);
      chk("snooze_rering", bus.ringing, 1'b1);
    end
    secs(2);
    bus.snooze_btn = 1; step();
    chk("snooze4_ring", bus.ringing, 1'b1);
    chk("snooze4_nosnz", bus.snoozing, 1'b0);

    // Stop and snooze together: stop wins and the snooze budget resets
    bus.snooze_btn = 1; bus.stop_btn = 1; step();
    chk("stopwin_ring", bus.ringing, 1'b0);
    chk("stopwin_snz", bus.snoozing, 1'b0);
    chk("stopwin_alarm", bus.alarm, 1'b0);
    set_time(6, 29, 59);
    secs(1);
    bus.snooze_btn = 1; step();
    chk("snooze_budget_reset", bus.snoozing, 1'b1);
    bus.stop_btn = 1; step();

    // Reset mid-ring
    set_time(6, 29, 59);
    secs(2);
    chk("pre_reset_ring", bus.ringing, 1'b1);
    do_reset();
    step();
    chk("post_reset_idle", bus.ringing, 1'b0);
    set_time(6, 59, 59);
    secs(1);
    chk("post_reset_tgt", bus.ringing, 1'b1);
    bus.stop_btn = 1; step();

    // Randomized run around a 06:59 target, exercising chime/ring overlap
    bus.set_h = 8'h06; bus.set_m = 8'h59; bus.set_alarm = 1;
    step();
    bus.chime_en = 1; bus.alarm_en = 1;
    set_time(6, 58, 50);
    for (int c = 0; c < 30000; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        advance();
        if (hh == 7 && mm == 1) set_time(6, 58, 50);
        bus.sec_tick = 1;
      end
      bus.snooze_btn = ($urandom_range(0, 199) == 0);
      bus.stop_btn   = ($urandom_range(0, 2999) == 0);
      if ($urandom_range(0, 3999) == 0) bus.alarm_en = ~bus.alarm_en;
      if ($urandom_range(0, 999) == 0) bus.chime_en = ~bus.chime_en;
      if ($urandom_range(0, 2999) == 0) begin
        bus.set_alarm = 1;
        if ($urandom_range(0, 1) == 0) begin
          bus.set_h = 8'h06; bus.set_m = 8'h59;
        end else begin
          bus.set_h = 8'($urandom); bus.set_m = 8'($urandom);
        end
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
